// File: rtl/cpu_pkg.sv
// Shared types for the CPU phase sequencer: opcode map, state encoding, control vector.
package cpu_pkg;

  localparam int OPC_W = 3;

  localparam logic [OPC_W-1:0] HLT = 3'd0;
  localparam logic [OPC_W-1:0] SKZ = 3'd1;
  localparam logic [OPC_W-1:0] ADD = 3'd2;
  localparam logic [OPC_W-1:0] AND = 3'd3;
  localparam logic [OPC_W-1:0] XOR = 3'd4;
  localparam logic [OPC_W-1:0] LDA = 3'd5;
  localparam logic [OPC_W-1:0] STO = 3'd6;
  localparam logic [OPC_W-1:0] JMP = 3'd7;

  // PH0..PH7 share their phase number with the low three bits of the encoding.
  typedef enum logic [3:0] {
    S_PH0  = 4'd0,
    S_PH1  = 4'd1,
    S_PH2  = 4'd2,
    S_PH3  = 4'd3,
    S_PH4  = 4'd4,
    S_PH5  = 4'd5,
    S_PH6  = 4'd6,
    S_PH7  = 4'd7,
    S_RST  = 4'd8,
    S_HALT = 4'd9
  } state_t;

  typedef struct packed {
    logic       sel;
    logic       rd;
    logic       wr;
    logic       ld_ir;
    logic       ld_ac;
    logic       inc_pc;
    logic       ld_pc;
    logic       data_e;
    logic       halt;
    logic [2:0] phase;
  } ctrl_t;

  function automatic logic is_aluop(input logic [OPC_W-1:0] op);
    return (op == ADD) || (op == AND) || (op == XOR) || (op == LDA);
  endfunction

endpackage

// File: rtl/cpu_phase_ctrl_if.sv
// Sequencer <-> datapath bundle. Optional step input exists only with CPU_SINGLE_STEP_EN.
interface cpu_phase_ctrl_if;
  import cpu_pkg::*;

  logic [OPC_W-1:0] opcode;
  logic             zero;
`ifdef CPU_SINGLE_STEP_EN
  logic             step;
`endif
  logic             sel;
  logic             rd;
  logic             wr;
  logic             ld_ir;
  logic             ld_ac;
  logic             inc_pc;
  logic             ld_pc;
  logic             data_e;
  logic             halt;
  logic [2:0]       phase;

  modport master (
    input  opcode, zero,
`ifdef CPU_SINGLE_STEP_EN
    input  step,
`endif
    output sel, rd, wr, ld_ir, ld_ac, inc_pc, ld_pc, data_e, halt, phase
  );

  modport slave (
    output opcode, zero,
`ifdef CPU_SINGLE_STEP_EN
    output step,
`endif
    input  sel, rd, wr, ld_ir, ld_ac, inc_pc, ld_pc, data_e, halt, phase
  );

endinterface

// File: rtl/cpu_phase_decode.sv
// Combinational decode of the state being entered into the control vector it must present.
module cpu_phase_decode
  import cpu_pkg::*;
(
  input  state_t           next_state,
  input  logic [OPC_W-1:0] opcode,
  input  logic             zero,
  output ctrl_t            ctrl
);

  logic alu;
  assign alu = is_aluop(opcode);

  always_comb begin
    ctrl = '0;
    case (next_state)
      S_PH0: ctrl.sel = 1'b1;
      S_PH1: begin
        ctrl.sel = 1'b1;
        ctrl.rd  = 1'b1;
      end
      S_PH2, S_PH3: begin
        ctrl.sel   = 1'b1;
        ctrl.rd    = 1'b1;
        ctrl.ld_ir = 1'b1;
      end
      S_PH4: begin
        ctrl.inc_pc = 1'b1;
        ctrl.halt   = (opcode == HLT);
      end
      S_PH5: ctrl.rd = alu;
      S_PH6: begin
        // zero is only looked at on the way into PH6
        ctrl.rd     = alu;
        ctrl.inc_pc = (opcode == SKZ) && zero;
        ctrl.ld_pc  = (opcode == JMP);
        ctrl.data_e = (opcode == STO);
      end
      S_PH7: begin
        ctrl.rd     = alu;
        ctrl.ld_ac  = alu;
        ctrl.inc_pc = (opcode == JMP);
        ctrl.ld_pc  = (opcode == JMP);
        ctrl.wr     = (opcode == STO);
        ctrl.data_e = (opcode == STO);
      end
      S_HALT: begin
        ctrl.halt  = 1'b1;
        ctrl.phase = 3'd4;
      end
      default: ctrl = '0;
    endcase
    if (next_state inside {S_PH0, S_PH1, S_PH2, S_PH3, S_PH4, S_PH5, S_PH6, S_PH7})
      ctrl.phase = next_state[2:0];
  end

endmodule

// File: rtl/cpu_phase_ctrl.sv
// Eight-phase instruction sequencer; all outputs registered from the decode of the next state.
// Optional single-step hold in PH0 is enabled by defining CPU_SINGLE_STEP_EN.
module cpu_phase_ctrl
  import cpu_pkg::*;
#(
  parameter int OPC_W       = cpu_pkg::OPC_W,
  parameter int HALT_STICKY = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  cpu_phase_ctrl_if.master  bus
);

  state_t           state_reg;
  state_t           state_next;
  ctrl_t            ctrl_reg;
  ctrl_t            ctrl_next;
  logic [OPC_W-1:0] opc;
  logic             advance;

  assign opc = bus.opcode;

`ifdef CPU_SINGLE_STEP_EN
  assign advance = bus.step;
`else
  assign advance = 1'b1;
`endif

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_RST:  state_next = S_PH0;
      S_PH0:  state_next = advance ? S_PH1 : S_PH0;
      S_PH1:  state_next = S_PH2;
      S_PH2:  state_next = S_PH3;
      S_PH3:  state_next = S_PH4;
      S_PH4:  state_next = ((HALT_STICKY != 0) && (opc == HLT)) ? S_HALT : S_PH5;
      S_PH5:  state_next = S_PH6;
      S_PH6:  state_next = S_PH7;
      S_PH7:  state_next = S_PH0;
      S_HALT: state_next = S_HALT;
      default: state_next = S_RST;
    endcase
  end

  cpu_phase_decode u_decode (
    .next_state (state_next),
    .opcode     (opc),
    .zero       (bus.zero),
    .ctrl       (ctrl_next)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= S_RST;
      ctrl_reg  <= '0;
    end else begin
      state_reg <= state_next;
      ctrl_reg  <= ctrl_next;
    end
  end

  assign bus.sel    = ctrl_reg.sel;
  assign bus.rd     = ctrl_reg.rd;
  assign bus.wr     = ctrl_reg.wr;
  assign bus.ld_ir  = ctrl_reg.ld_ir;
  assign bus.ld_ac  = ctrl_reg.ld_ac;
  assign bus.inc_pc = ctrl_reg.inc_pc;
  assign bus.ld_pc  = ctrl_reg.ld_pc;
  assign bus.data_e = ctrl_reg.data_e;
  assign bus.halt   = ctrl_reg.halt;
  assign bus.phase  = ctrl_reg.phase;

endmodule

// File: tb/tb_cpu_phase_ctrl.sv
// Directed plus randomized check of cpu_phase_ctrl against a phase-table reference model.
module tb_cpu_phase_ctrl;
  import cpu_pkg::*;

  localparam int STICKY = 1;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  cpu_phase_ctrl_if bus ();

  cpu_phase_ctrl #(.HALT_STICKY(STICKY)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: phase number, parked flag, and the values the sequencer latched.
  bit       m_rst;
  bit       m_halt;
  int       m_ph;
  bit [2:0] m_op;
  bit       m_z;
  bit [4:0] pc;
  bit [4:0] operand;

  function automatic bit [11:0] expected();
    bit alu, sel, rd, wr, ldir, ldac, inc, ldpc, de, hlt;
    bit [2:0] ph;
    if (m_rst) return 12'h000;
    if (m_halt) return {9'b000000001, 3'd4};
    alu  = (m_op == ADD) || (m_op == AND) || (m_op == XOR) || (m_op == LDA);
    sel  = (m_ph <= 3);
    rd   = (m_ph >= 1 && m_ph <= 3) || (alu && m_ph >= 5);
    wr   = (m_op == STO) && (m_ph == 7);
    ldir = (m_ph == 2) || (m_ph == 3);
    ldac = alu && (m_ph == 7);
    inc  = (m_ph == 4) || (m_ph == 6 && m_op == SKZ && m_z) || (m_ph == 7 && m_op == JMP);
    ldpc = (m_op == JMP) && (m_ph >= 6);
    de   = (m_op == STO) && (m_ph >= 6);
    hlt  = (m_ph == 4) && (m_op == HLT);
    ph   = 3'(m_ph);
    return {sel, rd, wr, ldir, ldac, inc, ldpc, de, hlt, ph};
  endfunction

  function automatic bit [11:0] observed();
    return {bus.sel, bus.rd, bus.wr, bus.ld_ir, bus.ld_ac, bus.inc_pc,
            bus.ld_pc, bus.data_e, bus.halt, bus.phase};
  endfunction

  task automatic check(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h (model ph=%0d op=%0d)", tag, obs, exp, m_ph, m_op);
    end
  endtask

  task automatic tick(input string tag);
    // Bench datapath PC acts on the strobes visible during this cycle.
    if (bus.ld_pc) pc = operand;
    else if (bus.inc_pc) pc = pc + 5'd1;
    @(posedge clk);
    if (m_rst) begin
      m_rst = 1'b0;
      m_ph  = 0;
    end else if (!m_halt) begin
`ifdef CPU_SINGLE_STEP_EN
      if (m_ph == 0 && !bus.step) m_ph = 0;
      else
`endif
      if (m_ph == 4 && m_op == HLT && STICKY != 0) m_halt = 1'b1;
      else begin
        m_ph = (m_ph + 1) % 8;
        if (m_ph == 4) m_op = bus.opcode;
        if (m_ph == 6) m_z = bus.zero;
      end
    end
    #1;
    check(tag, observed(), expected());
  endtask

  task automatic async_reset();
    #2;
    rst_n  = 1'b0;
    m_rst  = 1'b1;
    m_halt = 1'b0;
    m_ph   = 0;
    #1;
    check("reset_immediate", observed(), 12'h000);
    @(posedge clk);
    #1;
    check("reset_held", observed(), 12'h000);
    rst_n = 1'b1;
    tick("reset_release");
  endtask

  task automatic run_instr(input bit [2:0] op, input bit z, input string tag);
    int guard;
    bus.opcode = op;
    bus.zero   = z;
`ifdef CPU_SINGLE_STEP_EN
    bus.step = 1'b1;
`endif
    guard = 0;
    do begin
      tick(tag);
`ifdef CPU_SINGLE_STEP_EN
      bus.step = 1'b0;
`endif
      guard++;
    end while (m_ph != 0 && !m_halt && guard < 20);
    if (guard >= 20) begin
      errors++;
      $display("FAIL %s instruction did not complete: observed phase=%0d required=0", tag, bus.phase);
    end
    $display("instr %s op=%0d zero=%0d cycles=%0d", tag, op, z, guard);
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    m_rst      = 1'b1;
    m_halt     = 1'b0;
    m_ph       = 0;
    m_op       = 3'd0;
    m_z        = 1'b0;
    pc         = 5'd0;
    operand    = 5'h1D;
    bus.opcode = LDA;
    bus.zero   = 1'b0;
`ifdef CPU_SINGLE_STEP_EN
    bus.step   = 1'b0;
`endif
    rst_n = 1'b0;
    #2;
    check("reset_state", observed(), 12'h000);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick("first_edge_ph0");

`ifdef CPU_SINGLE_STEP_EN
    for (int i = 0; i < 10; i++) tick("step_hold");
`endif

    run_instr(LDA, 1'b0, "lda");
    run_instr(STO, 1'b0, "sto");
    pc = 5'h02;
    run_instr(JMP, 1'b0, "jmp");
    checks++;
    assert (pc === 5'h1D) else begin
      errors++;
      $error("FAIL jmp_pc observed=%h expected=%h", pc, 5'h1D);
    end
    run_instr(SKZ, 1'b1, "skz_z1");
    run_instr(SKZ, 1'b0, "skz_z0");
    run_instr(ADD, 1'b1, "add");
    run_instr(XOR, 1'b0, "xor");

    run_instr(HLT, 1'b0, "hlt");
    for (int i = 0; i < 20; i++) tick("halt_hold");
    async_reset();

    // Reset in the middle of an instruction, right after the store strobe appears.
    bus.opcode = STO;
    while (m_ph != 7) tick("sto_to_ph7");
    async_reset();

    for (int i = 0; i < 400; i++) begin
      bus.zero = 1'($urandom);
`ifdef CPU_SINGLE_STEP_EN
      bus.step = ($urandom_range(0, 3) == 0);
`endif
      if (m_ph == 1) begin
        bus.opcode = ($urandom_range(0, 9) == 0) ? HLT : 3'($urandom_range(1, 7));
        $display("instr rand op=%0d", bus.opcode);
      end
      if (m_halt && $urandom_range(0, 3) == 0) async_reset();
      else if ($urandom_range(0, 99) == 0) async_reset();
      else tick("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
